// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating signed multiply-accumulate back end with valid/ready handshakes
module mac_accumulator #(
    parameter int ACC_W = 18,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    state_t state;
    logic [CNT_W:0] remaining;
    logic [CNT_W:0] len_ext;
    logic [ACC_W:0] sum;
    logic sat_pos;
    logic sat_neg;
    always_comb begin
        len_ext = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
        sum     = {{(ACC_W-15){p[15]}}, p} + {acc_out[ACC_W-1], acc_out};
        // one guard bit: top two bits disagree only on overflow
        sat_pos = ~sum[ACC_W] & sum[ACC_W-1];
        sat_neg = sum[ACC_W] & ~sum[ACC_W-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            acc_out   <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    remaining <= len_ext;
                    acc_out   <= '0;
                    sat       <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    acc_out   <= sat_pos ? ACC_MAX : sat_neg ? ACC_MIN : sum[ACC_W-1:0];
                    sat       <= sat | sat_pos | sat_neg;
                    remaining <= remaining - 1'b1;
                    if (remaining == {{CNT_W{1'b0}}, 1'b1}) begin
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for mac_accumulator
module tb_mac_accumulator;
    localparam int ACC_W = 18;
    localparam int CNT_W = 4;
    localparam int MAXV = 2**(ACC_W-1) - 1;
    localparam int MINV = -(2**(ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      p = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic             sat;
    logic             busy;

    typedef struct {int acc; bit s;} res_t;
    res_t sb[$];
    int total = 0;
    int bad = 0;
    int m_acc;
    bit m_sat;
    int m_rem;

    mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .p(p),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len = CNT_W'(l);
        m_acc = 0;
        m_sat = 1'b0;
        m_rem = (l == 0) ? 2**CNT_W : l;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_acc", $signed(acc_out), 0);
        chk("start_sat", sat, 0);
        chk("start_out_valid", out_valid, 0);
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        p = 16'(v);
        m_acc = m_acc + v;
        if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1'b1; end
        if (m_acc < MINV) begin m_acc = MINV; m_sat = 1'b1; end
        m_rem--;
        @(negedge clk);
        in_valid = 1'b0;
        chk("acc", $signed(acc_out), m_acc);
        chk("sat", sat, m_sat);
        chk("out_valid", out_valid, m_rem == 0);
        chk("in_ready", in_ready, m_rem != 0);
        if (m_rem == 0) sb.push_back('{m_acc, m_sat});
    endtask

    task automatic idle();
        in_valid = 1'b0;
        p = 16'($urandom);
        @(negedge clk);
        chk("idle_acc", $signed(acc_out), m_acc);
        chk("idle_in_ready", in_ready, 1);
    endtask

    task automatic result(input int stall, input bit poke);
        res_t r;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("res_valid", out_valid, 1);
            chk("res_acc", $signed(acc_out), r.acc);
            chk("res_sat", sat, r.s);
            repeat (stall) begin
                start = poke;
                len = 4'd7;
                @(negedge clk);
                start = 1'b0;
                chk("stall_valid", out_valid, 1);
                chk("stall_acc", $signed(acc_out), r.acc);
                chk("stall_sat", sat, r.s);
            end
            out_ready = 1'b1;
            start = poke;
            @(negedge clk);
            out_ready = 1'b0;
            start = 1'b0;
            chk("hs_valid", out_valid, 0);
            chk("hs_busy", busy, 0);
            chk("hs_in_ready", in_ready, 0);
        end
    endtask

    initial begin
        #3;
        chk("rst_acc", $signed(acc_out), 0);
        chk("rst_sat", sat, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_start(3);
        send(100); send(-50); send(7);
        result(0, 1'b0);

        do_start(9);
        repeat (9) send(16384);
        result(0, 1'b0);

        do_start(0);
        repeat (16) send(-16256);
        result(0, 1'b0);

        do_start(2);
        send(5); idle(); idle(); send(-3);
        result(4, 1'b0);

        do_start(5);
        send(1000); send(1000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_acc", $signed(acc_out), 0);
        chk("arst_sat", sat, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1);
        send(-1);
        result(0, 1'b0);

        do_start(3);
        send(1);
        start = 1'b1;
        len = 4'd7;
        idle();
        start = 1'b0;
        send(2); send(3);
        result(2, 1'b1);
        @(negedge clk);
        chk("post_poke_busy", busy, 0);
        chk("post_poke_in_ready", in_ready, 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
